count_seq_ctrl: RTL and testbench

- Sequencing controller for the team's negative-edge, async-clear counter datapath.
- Accepts a start request with a programmable terminal count and runs the counter in one-shot or periodic mode.
- Supports pause, abort and a done/acknowledge handshake.
- Sits between the system control logic and the counter register bank; emits the count value, a wrap tick and status.

---
 rtl/count_ctrl_pkg.sv | 18 +
 rtl/count_reg_neg.sv | 30 +++
 rtl/count_seq_ctrl.sv | 145 ++++++++++++++
 tb/tb_count_seq_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared encodings for the negedge counter sequencing controller.
// State codes, mode codes and default sizing used by count_seq_ctrl and count_reg_neg.
package count_ctrl_pkg;

   localparam int DEF_WIDTH    = 3;
   localparam int DEF_PRESCALE = 4;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/count_reg_neg.sv
// WIDTH-bit falling-edge register with async active-low clear.
// Load-zero has priority over the enable so the controller can clear and advance with one decode.
module count_reg_neg
   import count_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             Clk,
   input  logic             ClrN,
   input  logic             i_en,
   input  logic             i_zero,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(negedge Clk or negedge ClrN) begin
      if (!ClrN) begin
         r_q <= '0;
      end else if (i_zero) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Start/pause/abort sequencer driving a negedge counter with one-shot and periodic modes.
// Define COUNT_PRESCALE_EN to advance only on every PRESCALE-th RUN edge.
module count_seq_ctrl
   import count_ctrl_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic             Clk,
   input  logic             ClrN,
   input  logic             Start,
   input  logic             Stop,
   input  logic             Pause,
   input  logic             Mode,
   input  logic [WIDTH-1:0] TermCnt,
   input  logic             DoneAck,
   output logic [WIDTH-1:0] Count,
   output logic             Tick,
   output logic             Busy,
   output logic             Done
);

   if (WIDTH < 2 || WIDTH > 16 || PRESCALE < 1 || PRESCALE > 256) begin : g_bad_params
      $error("count_seq_ctrl: WIDTH must be 2..16 and PRESCALE 1..256");
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_tc;
   logic             r_mode;
   logic             r_tick;

   logic [WIDTH-1:0] w_count;
   logic [WIDTH-1:0] w_cnt_d;
   logic             w_cnt_en;
   logic             w_cnt_zero;
   logic             w_step;
   logic             w_hit;

`ifdef COUNT_PRESCALE_EN
   localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] r_pre;

   // Zeroed throughout IDLE so every run starts a fresh prescale period; frozen in PAUSE.
   always_ff @(negedge Clk or negedge ClrN) begin
      if (!ClrN) begin
         r_pre <= '0;
      end else if (r_state == ST_IDLE) begin
         r_pre <= '0;
      end else if (r_state == ST_RUN && !Stop && !Pause) begin
         r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
      end
   end

   assign w_step = (r_pre == PRE_LAST);
`else
   assign w_step = 1'b1;
`endif

   assign w_hit   = w_step && (w_count == r_tc);
   assign w_cnt_d = w_count + 1'b1;

   always_comb begin
      w_cnt_en   = 1'b0;
      w_cnt_zero = 1'b0;
      unique case (r_state)
         ST_IDLE: w_cnt_zero = 1'b1;
         ST_RUN: begin
            if (Stop) begin
               w_cnt_zero = 1'b1;
            end else if (!Pause && w_step) begin
               if (w_count == r_tc) begin
                  w_cnt_zero = (r_mode == MODE_PERIODIC);
               end else begin
                  w_cnt_en = 1'b1;
               end
            end
         end
         ST_PAUSE: w_cnt_zero = Stop;
         ST_DONE:  w_cnt_zero = DoneAck;
      endcase
   end

   count_reg_neg #(
      .WIDTH (WIDTH)
   ) u_count_reg (
      .Clk    (Clk),
      .ClrN   (ClrN),
      .i_en   (w_cnt_en),
      .i_zero (w_cnt_zero),
      .i_d    (w_cnt_d),
      .o_q    (w_count)
   );

   always_ff @(negedge Clk or negedge ClrN) begin
      if (!ClrN) begin
         r_state <= ST_IDLE;
         r_tc    <= '0;
         r_mode  <= MODE_ONESHOT;
         r_tick  <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (Start) begin
                  r_tc    <= TermCnt;
                  r_mode  <= Mode;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (Stop) begin
                  r_state <= ST_IDLE;
               end else if (Pause) begin
                  r_state <= ST_PAUSE;
               end else if (w_hit) begin
                  r_tick <= 1'b1;
                  if (r_mode == MODE_ONESHOT) begin
                     r_state <= ST_DONE;
                  end
               end
            end
            ST_PAUSE: begin
               if (Stop) begin
                  r_state <= ST_IDLE;
               end else if (!Pause) begin
                  r_state <= ST_RUN;
               end
            end
            ST_DONE: begin
               if (DoneAck) begin
                  r_state <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign Count = w_count;
   assign Tick  = r_tick;
   assign Busy  = (r_state == ST_RUN) || (r_state == ST_PAUSE);
   assign Done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl (WIDTH = 3); outputs sampled 1 ns after each falling edge.
module tb_count_seq_ctrl;

   logic       Clk;
   logic       ClrN;
   logic       Start;
   logic       Stop;
   logic       Pause;
   logic       Mode;
   logic [2:0] TermCnt;
   logic       DoneAck;
   logic [2:0] Count;
   logic       Tick;
   logic       Busy;
   logic       Done;

   int checks = 0;
   int errors = 0;

   count_seq_ctrl #(
      .WIDTH    (3),
      .PRESCALE (1)
   ) dut (
      .Clk     (Clk),
      .ClrN    (ClrN),
      .Start   (Start),
      .Stop    (Stop),
      .Pause   (Pause),
      .Mode    (Mode),
      .TermCnt (TermCnt),
      .DoneAck (DoneAck),
      .Count   (Count),
      .Tick    (Tick),
      .Busy    (Busy),
      .Done    (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input int cnt, input bit tk, input bit bsy, input bit dn);
      chk({tag, ".count"}, 16'(Count), 16'(cnt));
      chk({tag, ".tick"},  16'(Tick),  16'(tk));
      chk({tag, ".busy"},  16'(Busy),  16'(bsy));
      chk({tag, ".done"},  16'(Done),  16'(dn));
      $display("t=%0t %s: Count=%0d Tick=%0b Busy=%0b Done=%0b", $time, tag, Count, Tick, Busy, Done);
   endtask

   task automatic edge_step();
      @(negedge Clk);
      #1;
   endtask

   task automatic start_run(input logic [2:0] tc, input logic md);
      TermCnt = tc;
      Mode    = md;
      Start   = 1'b1;
      edge_step();
      Start   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      ClrN = 1'b0; Start = 1'b0; Stop = 1'b0; Pause = 1'b0;
      Mode = 1'b0; TermCnt = 3'd0; DoneAck = 1'b0;
      #3;
      expect_out("reset", 0, 0, 0, 0);
      #4 ClrN = 1'b1;

      // One-shot, TermCnt = 3
      start_run(3'd3, 1'b0);
      expect_out("oneshot.start", 0, 0, 1, 0);
      for (int k = 1; k <= 3; k++) begin
         edge_step();
         expect_out("oneshot.inc", k, 0, 1, 0);
      end
      edge_step();
      expect_out("oneshot.term", 3, 1, 0, 1);
      edge_step();
      expect_out("oneshot.hold", 3, 0, 0, 1);
      Start = 1'b1; Stop = 1'b1; Pause = 1'b1;
      edge_step();
      expect_out("done.ignore", 3, 0, 0, 1);
      Start = 1'b0; Stop = 1'b0; Pause = 1'b0;
      DoneAck = 1'b1;
      edge_step();
      DoneAck = 1'b0;
      expect_out("oneshot.ack", 0, 0, 0, 0);

      // Periodic, TermCnt = 2; later TermCnt/Mode changes must not matter
      start_run(3'd2, 1'b1);
      TermCnt = 3'd5;
      Mode    = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         edge_step();
         expect_out("periodic", k % 3, (k % 3) == 0, 1, 0);
      end
      Stop = 1'b1;
      edge_step();
      Stop = 1'b0;
      expect_out("periodic.stop", 0, 0, 0, 0);

      // Pause at Count = 4, TermCnt = 6
      start_run(3'd6, 1'b1);
      for (int k = 1; k <= 4; k++) edge_step();
      expect_out("pause.pre", 4, 0, 1, 0);
      Pause = 1'b1;
      for (int k = 0; k < 3; k++) begin
         edge_step();
         expect_out("pause.hold", 4, 0, 1, 0);
      end
      Pause = 1'b0;
      edge_step();
      expect_out("pause.resume", 4, 0, 1, 0);
      edge_step();
      expect_out("pause.inc", 5, 0, 1, 0);
      edge_step();
      expect_out("pause.attc", 6, 0, 1, 0);

      // Stop and Pause together at Count == tc_q
      Stop = 1'b1; Pause = 1'b1;
      edge_step();
      Stop = 1'b0; Pause = 1'b0;
      expect_out("prio.stop", 0, 0, 0, 0);

      // Full range, TermCnt = 7, one-shot
      start_run(3'd7, 1'b0);
      for (int k = 1; k <= 7; k++) edge_step();
      expect_out("full.top", 7, 0, 1, 0);
      edge_step();
      expect_out("full.term", 7, 1, 0, 1);
      DoneAck = 1'b1;
      edge_step();
      DoneAck = 1'b0;
      expect_out("full.ack", 0, 0, 0, 0);

      // TermCnt = 0, periodic
      start_run(3'd0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         edge_step();
         expect_out("tc0.periodic", 0, 1, 1, 0);
      end
      Stop = 1'b1;
      edge_step();
      Stop = 1'b0;
      expect_out("tc0.stop", 0, 0, 0, 0);

      // TermCnt = 0, one-shot
      start_run(3'd0, 1'b0);
      edge_step();
      expect_out("tc0.oneshot", 0, 1, 0, 1);
      DoneAck = 1'b1;
      edge_step();
      DoneAck = 1'b0;
      expect_out("tc0.ack", 0, 0, 0, 0);

      // Asynchronous clear mid-run at Count = 5
      start_run(3'd6, 1'b1);
      for (int k = 1; k <= 5; k++) edge_step();
      expect_out("areset.pre", 5, 0, 1, 0);
      #2 ClrN = 1'b0;
      #1;
      expect_out("areset.async", 0, 0, 0, 0);
      #2 ClrN = 1'b1;
      edge_step();
      expect_out("areset.idle", 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
